elastic_stage_reg: RTL and testbench
====================================

ELASTIC_STAGE_REG -- requirements
Module: elastic_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, width of the opaque payload (operands, immediate).
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, the PC loaded on exception request.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value held in reset.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clr  in  1  bubble insert: kill the output entry, keep PC/BD of the upstream instruction.
REQ-007 req  in  1  exception flush: empty the stage, present the handler PC.
REQ-008 in_valid  in  1  upstream entry valid.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_pc / in_instr  in  32 / 32  upstream PC and instruction.
REQ-011 in_bd  in  1  branch-delay-slot flag.
REQ-012 in_exccode  in  5  pending exception code.
REQ-013 in_data  in  DATA_W  payload.
REQ-014 out_valid  out  1  output entry valid.
REQ-015 out_ready  in  1  downstream accepts the output entry.
REQ-016 out_pc, out_instr, out_bd, out_exccode, out_data  out  32, 32, 1, 5, DATA_W  registered copy of the output entry.
REQ-017 bubble_cnt  out  16  count of bubbles inserted by clr since reset, saturating.

Function
REQ-018 Storage SHALL be a main entry M (drives out_*) plus, when configured, a skid entry S; entry = {pc, instr, bd, exccode, data, valid}.
REQ-019 Accept SHALL occur on in_valid && in_ready; drain SHALL occur on out_valid && out_ready.
REQ-020 On drain or M empty, M SHALL load S if S is full, else the accepted input, else become invalid.
REQ-021 An input accepted while M stays occupied SHALL be written to S; S SHALL be emptied when moved to M.
REQ-022 Order SHALL be preserved; no entry SHALL be duplicated or lost except by clr/req.
REQ-023 Latency in -> out SHALL be exactly one cycle when the stage is empty.
REQ-024 Priority SHALL be reset > req > clr > normal operation.
REQ-025 req: next edge M <= {HANDLER_PC, instr 0, bd 0, exccode 0, data 0, valid 1}; S emptied; no accept that cycle.
REQ-026 clr: next edge M <= {in_pc, instr 0, in_bd, exccode 0, data 0, valid 1}; S unchanged; no accept that cycle; bubble_cnt += 1 unless at 16'hFFFF.
REQ-027 in_ready SHALL be 0 during any cycle in which reset, req or clr is high.
REQ-028 out_* SHALL change only at a clock edge; there SHALL be no combinational path from in_* to out_*.
REQ-029 Holding: while out_valid && !out_ready and no clr/req, all out_* SHALL hold stable.

Reset
REQ-030 On reset: out_valid 0, out_pc RESET_PC, out_instr/out_bd/out_exccode/out_data 0, S empty, bubble_cnt 0.
REQ-031 in_ready SHALL be 0 in the cycle reset is high and SHALL be 1 in the first cycle after reset is deasserted.
REQ-032 Reset asserted mid-transfer SHALL discard M and S with no accept or drain counted.

Configuration
REQ-033 Macro ELASTIC_SKID_EN SHALL select the buffering mode.
REQ-034 With ELASTIC_SKID_EN defined: S present; in_ready is a register equal to "S empty" (excluding REQ-027 forcing), so no combinational out_ready -> in_ready path.
REQ-035 Without it: no S; in_ready = !out_valid || out_ready (combinational); the accept/drain/clr/req rules otherwise apply unchanged.

Verification
REQ-036 Reset, then in_valid=1 with pc 0x3000 and out_ready=1 -> out_valid=1, out_pc=0x3000 one cycle later; stream of 8 entries emerges in order, 1 per cycle.
REQ-037 (SKID) M full, out_ready=0, accept pc 0x3004 -> S full, in_ready=0 next cycle; out_ready=1 -> 0x3000 then 0x3004 out, in_ready returns to 1.
REQ-038 clr with in_pc=0x3010, in_bd=1 -> out_pc=0x3010, out_bd=1, out_instr=0, out_exccode=0, out_valid=1; bubble_cnt=1.
REQ-039 req and clr together with S full -> out_pc=0x4180, out_bd=0, S empty, bubble_cnt unchanged.
REQ-040 Preload bubble_cnt to 0xFFFF via 65535 clr pulses, one more clr -> stays 0xFFFF; reset with entries held in M and S -> out_valid=0, out_pc=RESET_PC, bubble_cnt=0.

Source files
------------

// File: rtl/elastic_stage_reg.sv
// Elastic pipeline stage register with bubble insert (clr) and exception flush (req).
// Define ELASTIC_SKID_EN to add a skid entry, which makes in_ready a pure register.
module elastic_stage_reg #(
  parameter int          DATA_W     = 96,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_bd,
  input  logic [4:0]        in_exccode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_bd,
  output logic [4:0]        out_exccode,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       bubble_cnt
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              bd;
    logic [4:0]        exccode;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_e, hdl_e, bub_e, rst_e, src_e, m_q;
  logic   m_vld, src_vld, flush, accept, drain, m_load;

  assign in_e  = {in_pc, in_instr, in_bd, in_exccode, in_data};
  assign hdl_e = {HANDLER_PC, 32'd0, 1'b0, 5'd0, {DATA_W{1'b0}}};
  assign bub_e = {in_pc, 32'd0, in_bd, 5'd0, {DATA_W{1'b0}}};
  assign rst_e = {RESET_PC, {(32 + 1 + 5 + DATA_W){1'b0}}};

  assign flush  = reset | req | clr;
  assign accept = in_valid & in_ready;
  assign drain  = m_vld & out_ready;
  assign m_load = ~m_vld | drain;

`ifdef ELASTIC_SKID_EN
  entry_t s_q;
  logic   s_vld;

  // in_ready only looks at registered S state, so out_ready never reaches it.
  assign in_ready = ~s_vld & ~flush;
  assign src_e    = s_vld ? s_q : in_e;
  assign src_vld  = s_vld | accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_vld <= 1'b0;
      s_q   <= '0;
    end else if (req) begin
      s_vld <= 1'b0;
    end else if (!clr) begin
      if (m_load) begin
        s_vld <= 1'b0;
      end else if (accept) begin
        s_vld <= 1'b1;
        s_q   <= in_e;
      end
    end
  end
`else
  assign in_ready = (~m_vld | out_ready) & ~flush;
  assign src_e    = in_e;
  assign src_vld  = accept;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld <= 1'b0;
      m_q   <= rst_e;
    end else if (req) begin
      m_vld <= 1'b1;
      m_q   <= hdl_e;
    end else if (clr) begin
      m_vld <= 1'b1;
      m_q   <= bub_e;
    end else if (m_load) begin
      m_vld <= src_vld;
      if (src_vld) m_q <= src_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                  bubble_cnt <= 16'd0;
    else if (!req && clr && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end

  assign out_valid   = m_vld;
  assign out_pc      = m_q.pc;
  assign out_instr   = m_q.instr;
  assign out_bd      = m_q.bd;
  assign out_exccode = m_q.exccode;
  assign out_data    = m_q.data;

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Self-checking bench for elastic_stage_reg: directed scenarios plus random traffic
// against a queue model of the stage contents.
module tb_elastic_stage_reg;
  localparam int          DW  = 96;
  localparam logic [31:0] HPC = 32'h0000_4180;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef ELASTIC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          bd;
    logic [4:0]    exc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0, reset = 1'b0, clr = 1'b0, req = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_bd, in_bd = 1'b0;
  logic [31:0]   in_pc = '0, in_instr = '0, out_pc, out_instr;
  logic [4:0]    in_exccode = '0, out_exccode;
  logic [DW-1:0] in_data = '0, out_data;
  logic [15:0]   bubble_cnt;

  elastic_stage_reg #(.DATA_W(DW), .HANDLER_PC(HPC), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .clr(clr), .req(req),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exccode(in_exccode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_bd(out_bd), .out_exccode(out_exccode),
    .out_data(out_data), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  ent_t        q[$];        // stage contents, q[0] is what the output should show
  logic [15:0] m_bcnt = '0;
  bit          exp_rdy, got_rdy;

  function automatic ent_t mk(logic [31:0] pc, logic [31:0] ins, logic bd, logic [4:0] ex, logic [DW-1:0] d);
    mk = {pc, ins, bd, ex, d};
  endfunction

  function automatic ent_t rnd(logic [31:0] pc);
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    rnd = mk(pc, r1, r2[0], r2[5:1], {$urandom, $urandom, $urandom});
  endfunction

  function automatic ent_t dut_out();
    dut_out = {out_pc, out_instr, out_bd, out_exccode, out_data};
  endfunction

  // One clock: drive inputs, record in_ready, advance model, return #1 after the edge.
  task automatic tick(input bit iv, input ent_t e, input bit orr, input bit c, input bit r);
    bit   acc, drn;
    ent_t s[$];
    in_valid = iv; in_pc = e.pc; in_instr = e.instr; in_bd = e.bd;
    in_exccode = e.exc; in_data = e.data; out_ready = orr; clr = c; req = r;
    #1;
    got_rdy = in_ready;
    exp_rdy = !c && !r && ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || orr));
    acc = iv && exp_rdy;
    drn = (q.size() > 0) && orr;
    if (r) begin
      q.delete();
      q.push_back(mk(HPC, 32'd0, 1'b0, 5'd0, '0));
    end else if (c) begin
      s = q;
      q.delete();
      q.push_back(mk(e.pc, 32'd0, e.bd, 5'd0, '0));
      if (s.size() > 1) q.push_back(s[1]);
      if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Reset with live traffic on the inputs; nothing may be accepted or survive.
  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; clr = 1'b0; req = 1'b0;
    in_pc = 32'h0000_7777;
    #1; got_rdy = in_ready;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); m_bcnt = '0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (got_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_during got %b exp 0", got_rdy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_pc !== RPC) begin n_bad++; $display("FAIL rst_out_pc got %h exp %h", out_pc, RPC); end
    n_cmp++; if ({out_instr, out_bd, out_exccode, out_data} !== '0) begin n_bad++;
      $display("FAIL rst_out_fields got %h/%b/%h/%h exp 0", out_instr, out_bd, out_exccode, out_data); end
    n_cmp++; if (bubble_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_bubble_cnt got %0d exp 0", bubble_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    ent_t e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      e = rnd(32'h3000 + 32'(4 * i));
      tick(1'b1, e, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (got_rdy !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, got_rdy); end
      n_cmp++; if (out_valid !== 1'b1 || dut_out() !== e) begin n_bad++;
        $display("FAIL stream_entry[%0d] got v%b %h exp v1 %h", i, out_valid, dut_out(), e); end
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    ent_t a, b;
    apply_reset();
    a = rnd(32'h3000); b = rnd(32'h3004);
    tick(1'b1, a, 1'b0, 1'b0, 1'b0);
    tick(1'b1, b, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (got_rdy !== exp_rdy) begin n_bad++; $display("FAIL bp_second_accept got %b exp %b", got_rdy, exp_rdy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_full got %b exp 0", in_ready); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || dut_out() !== a) begin n_bad++;
      $display("FAIL bp_hold got v%b %h exp v1 %h", out_valid, dut_out(), a); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifdef ELASTIC_SKID_EN
    n_cmp++; if (out_valid !== 1'b1 || dut_out() !== b) begin n_bad++;
      $display("FAIL bp_skid_second got v%b %h exp v1 %h", out_valid, dut_out(), b); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_back got %b exp 1", in_ready); end
  endtask

  task automatic test_clr();
    ent_t e;
    apply_reset();
    e = mk(32'h3010, 32'hDEAD_BEEF, 1'b1, 5'd3, {3{32'hA5A5_5A5A}});
    tick(1'b1, e, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (got_rdy !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready got %b exp 0", got_rdy); end
    n_cmp++; if (out_valid !== 1'b1 || dut_out() !== mk(32'h3010, 32'd0, 1'b1, 5'd0, '0)) begin n_bad++;
      $display("FAIL clr_bubble got v%b %h exp v1 pc 3010 bd 1 rest 0", out_valid, dut_out()); end
    n_cmp++; if (bubble_cnt !== 16'd1) begin n_bad++; $display("FAIL clr_bubble_cnt got %0d exp 1", bubble_cnt); end
  endtask

  task automatic test_req_clr();
    apply_reset();
    tick(1'b1, rnd(32'h3000), 1'b0, 1'b0, 1'b0);
    tick(1'b1, rnd(32'h3004), 1'b0, 1'b0, 1'b0);
    tick(1'b1, rnd(32'h3008), 1'b1, 1'b1, 1'b1);
    n_cmp++; if (got_rdy !== 1'b0) begin n_bad++; $display("FAIL req_in_ready got %b exp 0", got_rdy); end
    n_cmp++; if (out_valid !== 1'b1 || dut_out() !== mk(HPC, 32'd0, 1'b0, 5'd0, '0)) begin n_bad++;
      $display("FAIL req_handler got v%b %h exp v1 pc %h rest 0", out_valid, dut_out(), HPC); end
    n_cmp++; if (bubble_cnt !== 16'd0) begin n_bad++; $display("FAIL req_bubble_cnt got %0d exp 0", bubble_cnt); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL req_skid_emptied got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    ent_t        e;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      e = rnd($urandom);
      tick(r[1:0] != 2'b00, e, r[3:2] != 2'b00, r[8:4] == 5'd0, r[14:9] == 6'd0);
      n_cmp++; if (got_rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", i, got_rdy, exp_rdy); end
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_bad++;
        $display("FAIL rnd_out_valid[%0d] got %b exp %b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (dut_out() !== q[0]) begin n_bad++; $display("FAIL rnd_entry[%0d] got %h exp %h", i, dut_out(), q[0]); end
      end
      n_cmp++; if (bubble_cnt !== m_bcnt) begin n_bad++; $display("FAIL rnd_bubble_cnt[%0d] got %0d exp %0d", i, bubble_cnt, m_bcnt); end
    end
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    for (int i = 0; i < 65535; i++) tick(1'b0, mk(32'h10, '0, 1'b0, '0, '0), 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bubble_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h exp ffff", bubble_cnt); end
    tick(1'b0, mk(32'h10, '0, 1'b0, '0, '0), 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bubble_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h exp ffff", bubble_cnt); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, rnd(32'h3000), 1'b0, 1'b0, 1'b0);
    tick(1'b1, rnd(32'h3004), 1'b0, 1'b0, 1'b0);
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== RPC) begin n_bad++;
      $display("FAIL midreset_out got v%b pc %h exp v0 pc %h", out_valid, out_pc, RPC); end
    n_cmp++; if (bubble_cnt !== 16'd0) begin n_bad++; $display("FAIL midreset_bubble got %h exp 0", bubble_cnt); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_skid_gone got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_clr();
    test_req_clr();
    test_random();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
